// File: rtl/pc_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch-stage program counter with stall, redirect and flush.
//            Macro PC_DELAY_SLOT_EN selects MIPS delay-slot branch behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] PC_INC    = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  output logic              chip_en,
  output logic [ADDR_W-1:0] pc,
  output logic              in_delay_slot
);

  localparam logic [0:0]        c_st_off     = 1'b0;
  localparam logic [0:0]        c_st_run     = 1'b1;
  localparam logic [ADDR_W-1:0] c_align_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic              w_run;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_seq;
  logic [ADDR_W-1:0] w_new_pc_al;
  logic [ADDR_W-1:0] w_br_tgt_al;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_pc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_off;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leave OFF on the first edge out of reset; only reset returns.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_off: w_state_next = c_st_run;
      c_st_run: w_state_next = c_st_run;
      default:  w_state_next = c_st_off;
    endcase
  end

  // State outputs
  always_comb begin
    w_run   = (r_state == c_st_run);
    chip_en = w_run;
  end

  assign w_pc_seq    = r_pc + PC_INC;
  assign w_new_pc_al = new_pc & c_align_mask;
  assign w_br_tgt_al = branch_target & c_align_mask;

`ifdef PC_DELAY_SLOT_EN
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_tgt;

  // A taken branch is parked here while the delay-slot instruction is fetched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_tgt   <= '0;
    end else if (w_run) begin
      if (flush) begin
        r_pend_valid <= 1'b0;
      end else if (!stall) begin
        if (r_pend_valid) begin
          r_pend_valid <= 1'b0;
        end else if (branch_flag) begin
          r_pend_valid <= 1'b1;
          r_pend_tgt   <= w_br_tgt_al;
        end
      end
    end
  end

  assign w_redirect    = r_pend_valid;
  assign w_redirect_pc = r_pend_tgt;
  assign in_delay_slot = r_pend_valid;
`else
  assign w_redirect    = branch_flag;
  assign w_redirect_pc = w_br_tgt_al;
  assign in_delay_slot = 1'b0;
`endif

  // Priority: flush, then stall, then redirect, then sequential.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_VEC;
    end else if (w_run) begin
      if (flush) begin
        r_pc <= w_new_pc_al;
      end else if (!stall) begin
        r_pc <= w_redirect ? w_redirect_pc : w_pc_seq;
      end
    end
  end

  assign pc = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Self-checking bench for pc_gen: directed scenarios plus random
//            stimulus compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  localparam int          ADDR_W = 32;
  localparam longint      RV     = 64'h0;
  localparam longint      INC    = 64'h4;
  localparam longint      MASK   = 64'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b0;
  logic              branch_flag = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] new_pc = '0;
  logic              chip_en;
  logic [ADDR_W-1:0] pc;
  logic              in_delay_slot;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_VEC(32'h0),
    .PC_INC   (32'd4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .flush        (flush),
    .new_pc       (new_pc),
    .chip_en      (chip_en),
    .pc           (pc),
    .in_delay_slot(in_delay_slot)
  );

  always #5 clk = ~clk;

  // Behavioural model: fetching flag, current address, optional parked branch.
  bit     m_run  = 1'b0;
  longint m_pc   = RV;
  bit     m_pend = 1'b0;
  longint m_tgt  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_pc = RV; m_pend = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (flush) begin
      m_pc = longint'(new_pc) & MASK & ~64'h3; m_pend = 1'b0;
    end else if (!stall) begin
`ifdef PC_DELAY_SLOT_EN
      if (m_pend) begin
        m_pc = m_tgt; m_pend = 1'b0;
      end else begin
        if (branch_flag) begin
          m_tgt = longint'(branch_target) & ~64'h3; m_pend = 1'b1;
        end
        m_pc = (m_pc + INC) & MASK;
      end
`else
      if (branch_flag) m_pc = longint'(branch_target) & ~64'h3;
      else             m_pc = (m_pc + INC) & MASK;
`endif
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_chip_en", {63'd0, chip_en}, {63'd0, m_run});
      chk("cyc_pc", {32'd0, pc}, m_pc);
      chk("cyc_ds", {63'd0, in_delay_slot}, {63'd0, m_pend});
    end
  end

  task automatic step(input logic s, input logic bf, input logic [31:0] bt,
                      input logic fl, input logic [31:0] np);
    stall = s; branch_flag = bf; branch_target = bt; flush = fl; new_pc = np;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #2 reset = 1'b1;
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_chip_en", {63'd0, chip_en}, 64'd0);
    chk("rst_pc", {32'd0, pc}, 64'h0);
    chk("rst_ds", {63'd0, in_delay_slot}, 64'd0);
    // Noise on control inputs must be ignored while held in reset.
    stall = 1'b1; flush = 1'b1; new_pc = 32'h500; branch_flag = 1'b1;
    reset = 1'b0;
    step(1'b1, 1'b1, 32'h600, 1'b1, 32'h500);
    chk("edge1_chip_en", {63'd0, chip_en}, 64'd1);
    chk("edge1_pc", {32'd0, pc}, 64'h0);
    idle(); chk("edge2_pc", {32'd0, pc}, 64'h4);
    chk("model_pc_pin", m_pc, 64'h4);
    idle(); chk("edge3_pc", {32'd0, pc}, 64'h8);
    idle(); chk("edge4_pc", {32'd0, pc}, 64'hC);
    idle(); chk("pre_stall_pc", {32'd0, pc}, 64'h10);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("stall_hold_pc", {32'd0, pc}, 64'h10);
    end
    idle(); chk("stall_release_pc", {32'd0, pc}, 64'h14);

    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    chk("flush_to_20", {32'd0, pc}, 64'h20);
`ifdef PC_DELAY_SLOT_EN
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("ds_slot_pc", {32'd0, pc}, 64'h24);
    chk("ds_slot_flag", {63'd0, in_delay_slot}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 32'h700, 1'b0, 32'h0);
      chk("ds_stall_pc", {32'd0, pc}, 64'h24);
      chk("ds_stall_flag", {63'd0, in_delay_slot}, 64'd1);
    end
    step(1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
    chk("ds_target_pc", {32'd0, pc}, 64'h100);
    chk("ds_target_flag", {63'd0, in_delay_slot}, 64'd0);
    idle(); chk("ds_after_pc", {32'd0, pc}, 64'h104);
`else
    step(1'b0, 1'b1, 32'h103, 1'b0, 32'h0);
    chk("br_target_pc", {32'd0, pc}, 64'h100);
    chk("br_ds_flag", {63'd0, in_delay_slot}, 64'd0);
    idle(); chk("br_after_pc", {32'd0, pc}, 64'h104);
`endif
    step(1'b1, 1'b1, 32'h200, 1'b1, 32'h180);
    chk("flush_prio_pc", {32'd0, pc}, 64'h180);
    chk("flush_prio_ds", {63'd0, in_delay_slot}, 64'd0);
    step(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
`ifdef PC_DELAY_SLOT_EN
    chk("pend_slot_pc", {32'd0, pc}, 64'h184);
`else
    chk("br300_pc", {32'd0, pc}, 64'h300);
`endif
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h180);
    chk("flush_drop_pc", {32'd0, pc}, 64'h180);
    idle(); chk("flush_drop_next", {32'd0, pc}, 64'h184);

    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    chk("align_wrap_pc", {32'd0, pc}, 64'hFFFF_FFFC);
    idle(); chk("wrap_pc", {32'd0, pc}, 64'h0);
    idle(); idle();
    chk("pre_async_pc", {32'd0, pc}, 64'h8);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc", {32'd0, pc}, 64'h0);
    chk("async_rst_chip_en", {63'd0, chip_en}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(0, 9) < 2);
      branch_flag   = ($urandom_range(0, 9) < 3);
      branch_target = $urandom;
      flush         = ($urandom_range(0, 19) == 0);
      new_pc        = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 149) == 0) reset = 1'b1;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
